// File: rtl/ula_mc.sv
// ula_mc: multi-cycle ALU with a one-request handshake.
// Single-cycle ops complete with latency 1. MULU (shift-add) and DIVU
// (restoring) run one bit per cycle for WIDTH cycles. The result is held
// until the consumer takes it.
module ula_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             dz_flag
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [CW-1:0]    cnt;

  logic             accept, is_long, last_step;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_dz;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_long   = (op == OP_MULU) || ((op == OP_DIVU) && (in2 != '0));
  assign last_step = (cnt == CNT_LAST);
  assign shamt     = in1[SW-1:0];

  // Single-cycle results, including the DIVU-by-zero shortcut
  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_dz  = 1'b0;
    case (op)
      OP_AND:  alu_res = in1 & in2;
      OP_OR:   alu_res = in1 | in2;
      OP_ADD:  alu_res = in1 + in2;
      OP_XOR:  alu_res = in1 ^ in2;
      OP_SUB:  alu_res = in1 - in2;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLL:  alu_res = in2 << shamt;
      OP_SRL:  alu_res = in2 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in2) >>> shamt);
      OP_NOR:  alu_res = ~(in1 | in2);
      OP_DIVU: begin
        alu_res = '1;
        alu_hi  = in1;
        alu_dz  = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  // Multiply: acc_lo holds the multiplier, shifting out LSB-first while the
  // product grows into {acc_hi, acc_lo}. Divide: acc_lo holds the dividend,
  // shifting out MSB-first and receiving quotient bits; acc_hi is the remainder.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    step_hi  = '0;
    step_lo  = '0;
    if (op_q == OP_MULU) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_long ? CALC : DONE;
      CALC: if (last_step) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      b_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      zero_flag <= 1'b1;
      dz_flag   <= 1'b0;
    end else if (accept) begin
      op_q   <= op;
      b_q    <= in2;
      acc_hi <= '0;
      acc_lo <= in1;
      cnt    <= '0;
      if (is_long) begin
        dz_flag <= 1'b0;
      end else begin
        result    <= alu_res;
        result_hi <= alu_hi;
        zero_flag <= (alu_res == '0);
        dz_flag   <= alu_dz;
      end
    end else if (state == CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        result    <= step_lo;
        result_hi <= step_hi;
        zero_flag <= (step_lo == '0);
      end
    end
  end

endmodule

// File: tb/tb_ula_mc.sv
// Directed self-checking bench for ula_mc (WIDTH 32 and WIDTH 8 instances).
module tb_ula_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in1 = '0, in2 = '0;
  logic [3:0]  op = '0;
  logic        in_ready, out_valid, zero_flag, dz_flag;
  logic [31:0] result, result_hi;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  in1_8 = '0, in2_8 = '0;
  logic [3:0]  op8 = '0;
  logic        in_ready8, out_valid8, zero_flag8, dz_flag8;
  logic [7:0]  result8, result_hi8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ula_mc #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero_flag(zero_flag), .dz_flag(dz_flag)
  );

  ula_mc #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in1(in1_8), .in2(in2_8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .result_hi(result_hi8), .zero_flag(zero_flag8), .dz_flag(dz_flag8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request to the 32-bit DUT and count cycles until out_valid
  task automatic run32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    @(negedge clk);
    op8 = o; in1_8 = a; in2_8 = b; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid8 && lat < 100);
  endtask

  // Consume the pending result (out_ready already 1) and confirm release
  task automatic take32(input string tag);
    @(posedge clk);
    #1 chk({tag, "_release"}, {62'd0, out_valid, in_ready}, 64'h1);
  endtask

  // Single-cycle op: latency 1, expected low word, result_hi 0
  task automatic one(input string tag, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int lat;
    run32(o, a, b, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd1);
    chk({tag, "_res"}, {result_hi, result}, {32'h0, exp});
    chk({tag, "_zf"}, 64'(zero_flag), 64'(exp == 32'h0));
    take32(tag);
  endtask

  initial begin
    int  lat;
    logic seen;

    // Reset state, checked while rst_n is still low
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_res", {result_hi, result}, 64'h0);
    chk("rst_flags", {62'd0, zero_flag, dz_flag}, 64'h2);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // ADD wrap to zero
    one("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0);
    chk("add_dz", 64'(dz_flag), 64'd0);
    one("slt",   4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h1);
    one("sltu",  4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0);
    one("sra",   4'b1010, 32'd4, 32'h8000_0000, 32'hF800_0000);
    one("srl",   4'b1001, 32'd31, 32'h8000_0000, 32'h1);
    one("sll",   4'b1000, 32'd4, 32'h0000_0001, 32'h10);
    one("sub",   4'b0110, 32'h0, 32'h1, 32'hFFFF_FFFF);
    one("and",   4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    one("or",    4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    one("xor",   4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    one("nor",   4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF);
    one("illegal", 4'b0101, 32'h1, 32'h1, 32'h0);

    // MULU max x max
    run32(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("mulu_lat", 64'(lat), 64'd33);
    chk("mulu_res", {result_hi, result}, 64'hFFFF_FFFE_0000_0001);
    take32("mulu");

    // DIVU 100 / 7
    run32(4'b1110, 32'd100, 32'd7, lat);
    chk("divu_lat", 64'(lat), 64'd33);
    chk("divu_res", {result_hi, result}, {32'd2, 32'd14});
    chk("divu_dz", 64'(dz_flag), 64'd0);
    take32("divu");

    // DIVU by zero
    run32(4'b1110, 32'd5, 32'd0, lat);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_res", {result_hi, result}, {32'd5, 32'hFFFF_FFFF});
    chk("dz_flags", {62'd0, zero_flag, dz_flag}, 64'h1);
    take32("dz");

    // Next accept clears dz_flag
    one("dz_clear", 4'b0010, 32'd1, 32'd1, 32'd2);
    chk("dz_cleared", 64'(dz_flag), 64'd0);

    // Back-pressure: result held, in_valid ignored while in DONE
    out_ready = 1'b0;
    run32(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F, lat);
    chk("stall_lat", 64'(lat), 64'd1);
    in_valid = 1'b1; op = 4'b0010; in1 = 32'd1; in2 = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_res", {result_hi, result}, {32'h0, 32'hAAAA_AAAA});
      chk("stall_ctl", {60'd0, out_valid, in_ready, zero_flag, dz_flag}, 64'h8);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("stall_release", {62'd0, out_valid, in_ready}, 64'h1);
    @(negedge clk);
    chk("stall_noaccept", {31'd0, out_valid, result}, {32'd0, 32'hAAAA_AAAA});

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 4'b1101; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_res", {result_hi, result}, 64'h0);
    chk("abort_ctl", {60'd0, out_valid, in_ready, zero_flag, dz_flag}, 64'h6);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_novalid", 64'(seen), 64'd0);
    one("post_abort", 4'b0010, 32'd3, 32'd4, 32'd7);

    // WIDTH 8 instance
    run8(4'b1101, 8'hFF, 8'hFF, lat);
    chk("mul8_lat", 64'(lat), 64'd9);
    chk("mul8_res", {48'd0, result_hi8, result8}, 64'hFE01);
    @(posedge clk);
    #1 chk("mul8_release", 64'(out_valid8), 64'd0);
    run8(4'b1110, 8'd200, 8'd7, lat);
    chk("div8_lat", 64'(lat), 64'd9);
    chk("div8_res", {48'd0, result_hi8, result8}, {48'd0, 8'd4, 8'd28});
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ula_mc.md
ULA_MC -- requirements
Module: ula_mc

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; legal values are powers of two, 8..64.
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port in_valid  input  1  request present.
REQ-005 SHALL provide port in_ready  output  1  block can accept a request.
REQ-006 SHALL provide port in1  input  WIDTH  operand A; shift amount taken from in1[$clog2(WIDTH)-1:0].
REQ-007 SHALL provide port in2  input  WIDTH  operand B.
REQ-008 SHALL provide port op  input  4  operation select.
REQ-009 SHALL provide port out_valid  output  1  result registers hold a completed result.
REQ-010 SHALL provide port out_ready  input  1  consumer takes the result.
REQ-011 SHALL provide port result  output  WIDTH  low/primary result.
REQ-012 SHALL provide port result_hi  output  WIDTH  MUL high half / DIVU remainder, else 0.
REQ-013 SHALL provide port zero_flag  output  1  result == 0 (low word only).
REQ-014 SHALL provide port dz_flag  output  1  last DIVU had in2 == 0.

Function
REQ-015 SHALL use op codes: 0000 AND, 0001 OR, 0010 ADD (mod 2^WIDTH), 0011 XOR, 0110 SUB (mod 2^WIDTH), 0111 SLTU (unsigned A<B -> 1 else 0), 0100 SLT (signed A<B), 1000 SLL B by A, 1001 SRL B by A, 1010 SRA B by A, 1100 NOR, 1101 MULU, 1110 DIVU; any other code yields result 0, result_hi 0.
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-017 SHALL accept a request only on a cycle with in_valid && in_ready, capturing in1, in2, op; in_valid while not ready is ignored.
REQ-018 SHALL, for all ops other than MULU/DIVU, go IDLE -> DONE on accept, with out_valid high in the next cycle (latency 1), result_hi = 0.
REQ-019 SHALL compute MULU as unsigned WIDTH x WIDTH -> 2*WIDTH by iterative shift-add, one bit per cycle, IDLE -> CALC for exactly WIDTH cycles -> DONE; out_valid first high WIDTH+1 cycles after accept; {result_hi, result} = product.
REQ-020 SHALL compute DIVU by restoring division, one quotient bit per cycle, same WIDTH-cycle CALC timing; result = quotient, result_hi = remainder.
REQ-021 SHALL, for DIVU with in2 == 0, skip CALC (IDLE -> DONE, latency 1), give result all-ones, result_hi = in1, dz_flag = 1.
REQ-022 SHALL clear dz_flag on every accept other than DIVU-by-zero.
REQ-023 SHALL register zero_flag together with result; zero_flag = 1 when result == 0 regardless of result_hi.
REQ-024 SHALL hold result, result_hi, zero_flag, dz_flag, out_valid stable in DONE while out_ready = 0.
REQ-025 SHALL leave DONE for IDLE on the cycle out_valid && out_ready; out_valid deasserts next cycle; no new accept in that same cycle.
REQ-026 SHALL ignore op/in1/in2 changes during CALC and DONE (captured copies used).
REQ-027 SHALL use an iteration counter of $clog2(WIDTH)+1 bits, no wrap before terminal count WIDTH.

Reset
REQ-028 SHALL, on rst_n low, immediately force state IDLE, out_valid 0, result 0, result_hi 0, zero_flag 1, dz_flag 0, counter 0; in_ready 1 once rst_n high.
REQ-029 SHALL abort any CALC/DONE operation on reset with no result delivered afterward.

Verification
REQ-030 SHALL cover: ADD 0xFFFFFFFF + 1 (WIDTH 32) -> out_valid 1 cycle after accept, result 0, zero_flag 1, result_hi 0.
REQ-031 SHALL cover: SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-032 SHALL cover: MULU 0xFFFFFFFF x 0xFFFFFFFF -> out_valid 33 cycles after accept, result_hi 0xFFFFFFFE, result 0x00000001.
REQ-033 SHALL cover: DIVU 100 / 7 -> result 14, result_hi 2, dz_flag 0; DIVU 5 / 0 -> latency 1, result 0xFFFFFFFF, result_hi 5, dz_flag 1.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored; then out_ready 1 -> IDLE next cycle.
REQ-035 SHALL cover: rst_n asserted mid-MULU (cycle 10) -> outputs at reset values asynchronously, no out_valid after release; WIDTH=8 rerun of REQ-032 (0xFF x 0xFF -> 0xFE01, latency 9).
